// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer: FSM states, default counter width,
// and the mapping from an "asserted" mask to per-channel output levels.
package rst_seq_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_RELEASE,
        ST_DONE
    } state_t;

    // Asserted channels take their polarity level, released ones the opposite level.
    function automatic logic [31:0] pol_apply(input logic [31:0] asserted_mask,
                                              input logic [31:0] polarity);
        return ~(asserted_mask ^ polarity);
    endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Loadable saturating down-counter shared by the hold and gap phases.
// Latency: load visible next cycle; zero flag is combinational from the count register.
// Backpressure: none; load has priority over en, count sticks at zero.
module rst_seq_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    // No reset term: the parent holds load high while its reset is active.
    always_ff @(posedge clk) begin
        if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/rst_seq_gen.sv
// Multi-channel reset sequencer: hold all channels, then release one per gap interval.
// Latency: channel k releases H + k*G cycles after restart; no input reaches rst_o combinationally.
// Backpressure: none; trig_i (or the RST_SEQ_WDOG_EN watchdog) restarts from any state.
module rst_seq_gen
    import rst_seq_pkg::*;
#(
    parameter int                NUM_CH   = 4,
    parameter int                CNT_W    = CNT_W_DEF,
    parameter logic [NUM_CH-1:0] POLARITY = '0
`ifdef RST_SEQ_WDOG_EN
    ,
    parameter int                WDOG_W   = 20
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trig_i,
    input  logic [CNT_W-1:0]  cfg_hold_i,
    input  logic [CNT_W-1:0]  cfg_gap_i,
`ifdef RST_SEQ_WDOG_EN
    input  logic              wdog_kick_i,
`endif
    output logic [NUM_CH-1:0] rst_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_t             state_q, state_d;
    logic [NUM_CH-1:0]  mask_q, mask_d;
    logic [IDX_W-1:0]   idx_q, idx_d, idx_nxt;
    logic [CNT_W-1:0]   gap_q, gap_d;
    logic [CNT_W-1:0]   hold_m1;
    logic               tmr_load, tmr_en, tmr_zero;
    logic [CNT_W-1:0]   tmr_val;
    logic               wdog_fire;
    logic               restart;

`ifdef RST_SEQ_WDOG_EN
    logic [WDOG_W-1:0]  wdog_q;

    assign wdog_fire = (state_q == ST_DONE) && (&wdog_q) && !wdog_kick_i;

    always_ff @(posedge clk) begin
        if (!rst_n || (state_q != ST_DONE) || wdog_kick_i) begin
            wdog_q <= '0;
        end else if (!(&wdog_q)) begin
            wdog_q <= wdog_q + WDOG_W'(1);
        end
    end
`else
    assign wdog_fire = 1'b0;
`endif

    assign restart = !rst_n || trig_i || wdog_fire;
    // Hold of 0 behaves like 1; the timer counts down to zero, so load H-1.
    assign hold_m1 = (cfg_hold_i == '0) ? '0 : cfg_hold_i - CNT_W'(1);
    assign idx_nxt = idx_q + IDX_W'(1);

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        idx_d    = idx_q;
        gap_d    = gap_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        tmr_val  = hold_m1;
        if (restart) begin
            state_d  = ST_ASSERT;
            mask_d   = '1;
            idx_d    = '0;
            gap_d    = cfg_gap_i;
            tmr_load = 1'b1;
            tmr_val  = hold_m1;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    if (!tmr_zero) begin
                        tmr_en = 1'b1;
                    end else if ((gap_q == '0) || (NUM_CH == 1)) begin
                        mask_d  = '0;
                        state_d = ST_DONE;
                    end else begin
                        mask_d[0] = 1'b0;
                        idx_d     = '0;
                        state_d   = ST_RELEASE;
                        tmr_load  = 1'b1;
                        tmr_val   = gap_q - CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (!tmr_zero) begin
                        tmr_en = 1'b1;
                    end else begin
                        mask_d[idx_nxt] = 1'b0;
                        idx_d           = idx_nxt;
                        tmr_load        = 1'b1;
                        tmr_val         = gap_q - CNT_W'(1);
                        if (32'(idx_nxt) == NUM_CH - 1) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_ASSERT;
            mask_q  <= '1;
            idx_q   <= '0;
            gap_q   <= cfg_gap_i;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
        end
    end

    // Hold value is latched straight into the timer on entry; only gap needs its own copy.
    rst_seq_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    assign rst_o  = NUM_CH'(pol_apply(32'(mask_q), 32'(POLARITY)));
    assign busy_o = (state_q != ST_DONE);
    assign done_o = (state_q == ST_DONE);

endmodule

// File: tb/tb_rst_seq_gen.sv
// Scoreboard bench for rst_seq_gen: a timing-formula model pushes the expected outputs per cycle,
// an independent monitor pops and compares them against the DUT.
module tb_rst_seq_gen;

    localparam int         N   = 4;
    localparam int         CW  = 16;
    localparam logic [3:0] POL = 4'b1010;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          trig_i = 1'b0;
    logic [CW-1:0] cfg_hold_i = '0;
    logic [CW-1:0] cfg_gap_i = '0;
    logic [N-1:0]  rst_o;
    logic          busy_o;
    logic          done_o;
`ifdef RST_SEQ_WDOG_EN
    logic          wdog_kick_i = 1'b1;
`endif

    rst_seq_gen #(.NUM_CH(N), .CNT_W(CW), .POLARITY(POL)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .trig_i      (trig_i),
        .cfg_hold_i  (cfg_hold_i),
        .cfg_gap_i   (cfg_gap_i),
`ifdef RST_SEQ_WDOG_EN
        .wdog_kick_i (wdog_kick_i),
`endif
        .rst_o       (rst_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    // Model state: cycles since the last restart edge, and the latched hold/gap.
    int   t_m = 0;
    int   h_m = 1;
    int   g_m = 0;
    bit   armed = 1'b0;
    logic [5:0] exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [5:0] model_out(input int t, input int h, input int g);
        logic [3:0] r;
        logic       dn;
        for (int k = 0; k < N; k++) begin
            r[k] = (t >= h + k * g) ? ~POL[k] : POL[k];
        end
        dn = (t >= h + (N - 1) * g);
        return {r, ~dn, dn};
    endfunction

    task automatic step(input logic rn, input logic tg, input int hold, input int gap);
        @(negedge clk);
        rst_n      = rn;
        trig_i     = tg;
        cfg_hold_i = CW'(hold);
        cfg_gap_i  = CW'(gap);
        @(posedge clk);
        if (!rn || tg) begin
            t_m   = 0;
            h_m   = (hold == 0) ? 1 : hold;
            g_m   = gap;
            armed = 1'b1;
        end else if (t_m < 100000) begin
            t_m++;
        end
        if (armed) exp_q.push_back(model_out(t_m, h_m, g_m));
    endtask

    // Idle cycles keep scribbling on the config ports; only restart edges may latch them.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, $urandom_range(0, 9), $urandom_range(0, 9));
        end
    endtask

    initial begin : monitor
        logic [5:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if ({rst_o, busy_o, done_o} !== e) begin
                    n_err++;
                    $display("FAIL vec%0d t=%0d: got rst=%b busy=%b done=%b, want rst=%b busy=%b done=%b",
                             n_vec, t_m, rst_o, busy_o, done_o, e[5:2], e[1], e[0]);
                end
            end
        end
    end

    initial begin : stim
        int r;
        // hold=3 gap=2: releases at t=3,5,7,9
        step(1'b0, 1'b0, 3, 2);
        idle(12);
        // hold=0 gap=0: everything releases together at t=1
        step(1'b0, 1'b0, 0, 0);
        idle(4);
        // re-trigger while channel 1 is released
        step(1'b0, 1'b0, 3, 2);
        idle(6);
        step(1'b1, 1'b1, 2, 1);
        idle(10);
        // reset and trigger together during RELEASE
        step(1'b0, 1'b0, 1, 3);
        idle(4);
        step(1'b0, 1'b1, 5, 1);
        idle(10);
        // trigger from DONE, large gap
        step(1'b1, 1'b1, 1, 4);
        idle(16);
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 1)      step(1'b0, 1'b1, $urandom_range(0, 6), $urandom_range(0, 4));
            else if (r < 2) step(1'b0, 1'b0, $urandom_range(0, 6), $urandom_range(0, 4));
            else if (r < 5) step(1'b1, 1'b1, $urandom_range(0, 6), $urandom_range(0, 4));
            else            step(1'b1, 1'b0, $urandom_range(0, 9), $urandom_range(0, 9));
        end
        @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected vectors never checked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
